uart_tx_param: RTL and testbench
================================

# uart_tx_param

Parametrised UART transmitter for the ultrasonic board's serial telemetry path. It serialises one word per valid/ready handshake as start, data (LSB first), optional parity and 1–2 stop bits, at a fixed number of clocks per bit. It also drives a one-cycle-delayed monitor copy of the line and a frame-done pulse. It replaces the fixed 8N1, free-running transmitter, and sits between the measurement/formatting logic and the board TX pin.

## Interface
- CLKS_PER_BIT, 48: clock cycles per bit; legal range ≥ 2.
- DATA_BITS, 8: data bits per frame; legal range 5..9.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: legal values 1 or 2.
- Illegal parameter values stop elaboration with an error.

- clk  in  1  sole clock; all logic on its rising edge.
- rst_n  in  1  synchronous, active-low reset.
- tx_data  in  DATA_BITS  word to send; sampled only on accept.
- tx_valid  in  1  source has a word.
- tx_ready  out  1  block can accept; high only in IDLE.
- tx  out  1  serial line, idle high.
- tx_mon  out  1  `tx` registered one further cycle, for scope/loopback.
- busy  out  1  high from the accept cycle through the end of the last stop bit.
- tx_done  out  1  one-cycle pulse in the final cycle of the last stop bit.

## Operation
- States: IDLE, START, DATA, PAR, STOP.
- Accept = tx_valid && tx_ready at a rising edge. On accept:
  - tx_data latches into the shift register.
  - Parity latches: even = XOR of the data; odd = inverted XOR.
  - State goes to START.
  - tx_data changes after accept have no effect on the current frame.
- START: tx = 0 for CLKS_PER_BIT cycles, then DATA.
- DATA: tx = shift-register LSB, held CLKS_PER_BIT cycles; shift right and increment the bit index.
  - After bit DATA_BITS−1, go to PAR if PARITY ≠ 0, else to STOP.
- PAR: tx = latched parity bit for CLKS_PER_BIT cycles, then STOP.
- STOP: tx = 1 for STOP_BITS × CLKS_PER_BIT cycles.
  - tx_done pulses in the last of those cycles.
  - The next state is IDLE.
- IDLE: tx = 1, tx_ready = 1, busy = 0.
- Baud counter:
  - Width $clog2(CLKS_PER_BIT).
  - Counts 0..CLKS_PER_BIT−1 and clears at every bit boundary.
  - Never free-runs outside a frame.
- Bit index width: $clog2(DATA_BITS+1). Stop-bit counter width: 1 bit.
- tx, tx_mon, tx_ready, busy and tx_done are all registered outputs.

## Timing
- Reset (rst_n low at an edge) forces the following on the next edge:
  - tx = 1, tx_mon = 1, tx_ready = 0, busy = 0, tx_done = 0.
  - State = IDLE and all counters = 0.
- First edge with rst_n high: tx_ready = 1.
- Accept at edge N:
  - tx falls in the cycle following edge N; the start bit spans N+1..N+CLKS_PER_BIT.
  - busy = 1 and tx_ready = 0 from N+1.
- Frame length: F = (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) × CLKS_PER_BIT cycles.
- tx_done is high in cycle N+F. In cycle N+F+1: state IDLE, tx_ready = 1, busy = 0.
- Back-to-back frames:
  - Earliest next accept is edge N+F+1.
  - The line therefore stays high exactly one extra cycle beyond the stop bits; no other inter-frame gap is inserted.
- tx_valid held high continuously gives back-to-back frames with that one-cycle gap.
- tx_mon(t) = tx(t−1), always.
- Reset mid-frame: abort immediately on the next edge; tx = 1; no tx_done pulse; the word is lost.
- tx_valid while busy: ignored; tx_ready stays low; the source must hold the word.

## Test plan
- Defaults, tx_data = 0x55, single pulse of tx_valid:
  - tx = 0 for 48 cycles, then 1,0,1,0,1,0,1,0 at 48 cycles each, then 1 for 48 cycles.
  - tx_done at cycle N+480; tx_ready back at N+481.
- CLKS_PER_BIT = 4, PARITY = 2, STOP_BITS = 2, tx_data = 0x07:
  - Parity bit = 1; frame = 48 cycles.
  - tx_done at N+48; a UART model decodes 0x07 with no parity error.
- CLKS_PER_BIT = 4, PARITY = 1, DATA_BITS = 7, tx_data = 0x00:
  - Parity bit = 1; frame = 40 cycles.
  - tx_data toggled during the frame does not change the line.
- tx_valid held high with words 0xA5 then 0x3C (CLKS_PER_BIT = 4):
  - Second start bit begins exactly F+1 cycles after the first; both decode correctly.
  - tx_ready is low throughout each frame.
- Reset mid-data-bit (rst_n low for 1 cycle at N+20, CLKS_PER_BIT = 4):
  - tx = 1 on the next edge; busy = 0; no tx_done.
  - tx_ready = 1 on the first edge after release.
- tx_mon equals tx delayed by one cycle across all of the above; assertion-checked every cycle.

Source files
------------

// File: rtl/uart_tx_param_if.sv
// Word handshake between the telemetry formatter (master) and the UART transmitter (slave).
interface uart_tx_param_if #(
    parameter int DATA_BITS = 8
) ();
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;

    modport master (output tx_data, output tx_valid, input  tx_ready);
    modport slave  (input  tx_data, input  tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: start, DATA_BITS data bits (LSB first),
// optional parity, 1-2 stop bits, CLKS_PER_BIT clocks per bit.
// All outputs are registered. tx_mon is the line delayed by one cycle.
module uart_tx_param #(
    parameter int CLKS_PER_BIT = 48,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    uart_tx_param_if.slave   s_if,
    output logic             tx,
    output logic             tx_mon,
    output logic             busy,
    output logic             tx_done
);

    if (CLKS_PER_BIT < 2) begin : g_bad_cpb
        $error("uart_tx_param: CLKS_PER_BIT must be >= 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_db
        $error("uart_tx_param: DATA_BITS must be in 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_par
        $error("uart_tx_param: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
        $error("uart_tx_param: STOP_BITS must be 1 or 2");
    end

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);
    localparam logic             STOP_LAST = (STOP_BITS == 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PAR,
        S_STOP
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 stop_q, stop_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;
    logic                 tx_mon_q, tx_mon_d;
    logic                 tx_ready_q, tx_ready_d;
    logic                 busy_q, busy_d;
    logic                 tx_done_q, tx_done_d;
    logic                 bit_end;

    // Next-state, counters and the registered output values they imply.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        stop_d  = stop_q;
        shift_d = shift_q;
        par_d   = par_q;
        bit_end = (cnt_q == CNT_LAST);

        case (state_q)
            S_IDLE: begin
                cnt_d  = '0;
                idx_d  = '0;
                stop_d = 1'b0;
                if (s_if.tx_valid && tx_ready_q) begin
                    shift_d = s_if.tx_data;
                    par_d   = (PARITY == 1) ? ~(^s_if.tx_data) : (^s_if.tx_data);
                    state_d = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = S_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    shift_d = shift_q >> 1;
                    if (idx_q == IDX_LAST) begin
                        idx_d   = '0;
                        state_d = (PARITY != 0) ? S_PAR : S_STOP;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_PAR: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = S_STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (stop_q == STOP_LAST) begin
                        stop_d  = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        stop_d = stop_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                idx_d   = '0;
                stop_d  = 1'b0;
            end
        endcase

        // Outputs are derived from the upcoming state so they line up with it.
        case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shift_d[0];
            S_PAR:   tx_d = par_d;
            default: tx_d = 1'b1;
        endcase
        tx_mon_d   = tx_q;
        tx_ready_d = (state_d == S_IDLE);
        busy_d     = (state_d != S_IDLE);
        tx_done_d  = (state_d == S_STOP) && (cnt_d == CNT_LAST) && (stop_d == STOP_LAST);
    end

    // FSM, counters and output registers; reset aborts any frame in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            stop_q     <= 1'b0;
            tx_q       <= 1'b1;
            tx_mon_q   <= 1'b1;
            tx_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            tx_done_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            stop_q     <= stop_d;
            tx_q       <= tx_d;
            tx_mon_q   <= tx_mon_d;
            tx_ready_q <= tx_ready_d;
            busy_q     <= busy_d;
            tx_done_q  <= tx_done_d;
        end
    end

    // Word and parity storage; only meaningful once a word has been accepted.
    always_ff @(posedge clk) begin
        shift_q <= shift_d;
        par_q   <= par_d;
    end

    assign s_if.tx_ready = tx_ready_q;
    assign tx            = tx_q;
    assign tx_mon        = tx_mon_q;
    assign busy          = busy_q;
    assign tx_done       = tx_done_q;

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param: four parameterisations share one clock.
//   d0: defaults (48 clk/bit, 8N1)
//   d1: 4 clk/bit, 8 data, even parity, 2 stop
//   d2: 4 clk/bit, 7 data, odd parity, 1 stop
//   d3: 4 clk/bit, 8N1 (back-to-back and mid-frame reset)
module tb_uart_tx_param;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rst3_n = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [3:0] vld = '0;
    logic [8:0] dat [4];
    wire  [3:0] tx_w, mon_w, busy_w, done_w, rdy_w;

    uart_tx_param_if #(.DATA_BITS(8)) if0 ();
    uart_tx_param_if #(.DATA_BITS(8)) if1 ();
    uart_tx_param_if #(.DATA_BITS(7)) if2 ();
    uart_tx_param_if #(.DATA_BITS(8)) if3 ();

    assign if0.tx_valid = vld[0];
    assign if1.tx_valid = vld[1];
    assign if2.tx_valid = vld[2];
    assign if3.tx_valid = vld[3];
    assign if0.tx_data  = dat[0][7:0];
    assign if1.tx_data  = dat[1][7:0];
    assign if2.tx_data  = dat[2][6:0];
    assign if3.tx_data  = dat[3][7:0];
    assign rdy_w = {if3.tx_ready, if2.tx_ready, if1.tx_ready, if0.tx_ready};

    uart_tx_param d0 (
        .clk(clk), .rst_n(rst_n), .s_if(if0),
        .tx(tx_w[0]), .tx_mon(mon_w[0]), .busy(busy_w[0]), .tx_done(done_w[0])
    );
    uart_tx_param #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2)) d1 (
        .clk(clk), .rst_n(rst_n), .s_if(if1),
        .tx(tx_w[1]), .tx_mon(mon_w[1]), .busy(busy_w[1]), .tx_done(done_w[1])
    );
    uart_tx_param #(.CLKS_PER_BIT(4), .DATA_BITS(7), .PARITY(1), .STOP_BITS(1)) d2 (
        .clk(clk), .rst_n(rst_n), .s_if(if2),
        .tx(tx_w[2]), .tx_mon(mon_w[2]), .busy(busy_w[2]), .tx_done(done_w[2])
    );
    uart_tx_param #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) d3 (
        .clk(clk), .rst_n(rst3_n), .s_if(if3),
        .tx(tx_w[3]), .tx_mon(mon_w[3]), .busy(busy_w[3]), .tx_done(done_w[3])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Expected line level for frame bit b (0 = start bit).
    function automatic logic exp_bit(input logic [8:0] d, input int db, input int kind,
                                     input logic p, input int b);
        if (b == 0) return 1'b0;
        if (b <= db) return d[b-1];
        if (b == db + 1 && kind != 0) return p;
        return 1'b1;
    endfunction

    // tx_mon must equal the previous cycle's tx, except after an edge that applied reset.
    logic [3:0] last_tx = '1;
    logic [3:0] edge_rst = '0;
    bit armed = 1'b0;
    always @(posedge clk) edge_rst = {rst3_n, rst_n, rst_n, rst_n};
    always @(negedge clk) begin
        if (armed) begin
            for (int k = 0; k < 4; k++) begin
                if (edge_rst[k]) check($sformatf("tx_mon_d%0d", k), mon_w[k], last_tx[k]);
            end
        end
        last_tx = tx_w;
        armed   = 1'b1;
    end

    // One frame on DUT k; every cycle of the frame is compared, then the line is decoded.
    task automatic run_frame(input int k, input logic [8:0] data, input int cpb, input int db,
                             input int kind, input logic exp_par, input int f, input bit toggle);
        logic [11:0] cap;
        logic [8:0]  dec;
        logic        perr;
        int          b;
        string       nm;
        nm = $sformatf("d%0d", k);
        cap = '0;
        @(negedge clk);
        check({nm, "_rdy_pre"}, rdy_w[k], 1);
        dat[k] = data;
        vld[k] = 1'b1;
        @(negedge clk);
        vld[k] = 1'b0;
        for (int c = 1; c <= f; c++) begin
            if (c > 1) @(negedge clk);
            b = (c - 1) / cpb;
            check({nm, "_tx"},   tx_w[k],   exp_bit(data, db, kind, exp_par, b));
            check({nm, "_busy"}, busy_w[k], 1);
            check({nm, "_rdy"},  rdy_w[k],  0);
            check({nm, "_done"}, done_w[k], (c == f));
            if ((c - 1) % cpb == cpb / 2) cap[b] = tx_w[k];
            if (toggle) dat[k] = c[0] ? ~data : data;
        end
        @(negedge clk);
        check({nm, "_rdy_post"},  rdy_w[k],  1);
        check({nm, "_busy_post"}, busy_w[k], 0);
        check({nm, "_done_post"}, done_w[k], 0);
        check({nm, "_tx_post"},   tx_w[k],   1);
        dec = '0;
        for (int i = 0; i < db; i++) dec[i] = cap[i+1];
        check({nm, "_decode"}, dec, data);
        if (kind != 0) begin
            perr = (kind == 2) ? (cap[db+1] ^ (^dec)) : (cap[db+1] ^ ~(^dec));
            check({nm, "_par_bit"}, cap[db+1], exp_par);
            check({nm, "_par_err"}, perr, 0);
        end
        check({nm, "_stop"}, cap[db + 1 + ((kind != 0) ? 1 : 0)], 1);
        dat[k] = '0;
    endtask

    initial begin
        for (int k = 0; k < 4; k++) dat[k] = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("rst_tx_d%0d", k),   tx_w[k],   1);
            check($sformatf("rst_mon_d%0d", k),  mon_w[k],  1);
            check($sformatf("rst_rdy_d%0d", k),  rdy_w[k],  0);
            check($sformatf("rst_busy_d%0d", k), busy_w[k], 0);
            check($sformatf("rst_done_d%0d", k), done_w[k], 0);
        end
        rst_n  = 1'b1;
        rst3_n = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 4; k++) check($sformatf("rel_rdy_d%0d", k), rdy_w[k], 1);

        // 8N1 at 48 clk/bit, 0x55: F = 10*48 = 480
        run_frame(0, 9'h055, 48, 8, 0, 1'b0, 480, 1'b0);
        // 8E2 at 4 clk/bit, 0x07: parity 1, F = 12*4 = 48
        run_frame(1, 9'h007, 4, 8, 2, 1'b1, 48, 1'b0);
        // 7O1 at 4 clk/bit, 0x00 with tx_data toggling: parity 1, F = 10*4 = 40
        run_frame(2, 9'h000, 4, 7, 1, 1'b1, 40, 1'b1);

        // Back-to-back on d3 (F = 40): 0xA5 then 0x3C with tx_valid held high
        @(negedge clk);
        dat[3] = 9'h0A5;
        vld[3] = 1'b1;
        @(negedge clk);
        dat[3] = 9'h03C;
        for (int c = 1; c <= 81; c++) begin
            if (c > 1) @(negedge clk);
            if (c <= 40) begin
                check("b2b_tx1",   tx_w[3],   exp_bit(9'h0A5, 8, 0, 1'b0, (c - 1) / 4));
                check("b2b_rdy1",  rdy_w[3],  0);
                check("b2b_done1", done_w[3], (c == 40));
            end else if (c == 41) begin
                check("b2b_gap_tx",   tx_w[3],   1);
                check("b2b_gap_rdy",  rdy_w[3],  1);
                check("b2b_gap_busy", busy_w[3], 0);
            end else begin
                check("b2b_tx2",   tx_w[3],   exp_bit(9'h03C, 8, 0, 1'b0, (c - 42) / 4));
                check("b2b_rdy2",  rdy_w[3],  0);
                check("b2b_done2", done_w[3], (c == 81));
                if (c == 42) vld[3] = 1'b0;
            end
        end
        @(negedge clk);
        check("b2b_end_rdy",  rdy_w[3],  1);
        check("b2b_end_busy", busy_w[3], 0);

        // Mid-frame reset on d3: 0x00, reset sampled at edge N+20 (during data bit 3)
        @(negedge clk);
        dat[3] = 9'h000;
        vld[3] = 1'b1;
        @(negedge clk);
        vld[3] = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            if (c > 1) @(negedge clk);
            check("mrst_tx", tx_w[3], exp_bit(9'h000, 8, 0, 1'b0, (c - 1) / 4));
        end
        rst3_n = 1'b0;
        @(negedge clk);
        check("mrst_tx_after",   tx_w[3],   1);
        check("mrst_busy_after", busy_w[3], 0);
        check("mrst_done_after", done_w[3], 0);
        check("mrst_rdy_after",  rdy_w[3],  0);
        rst3_n = 1'b1;
        @(negedge clk);
        check("mrst_rdy_release", rdy_w[3], 1);
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            check("mrst_idle_done", done_w[3], 0);
            check("mrst_idle_tx",   tx_w[3],   1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
